// File: rtl/prbs_gen_chk.sv
// prbs_gen_chk: parametrised PRBS word generator plus
// self-synchronising checker with lock FSM and error count.
module prbs_gen_chk #(
  parameter int                    POLY_ORDER = 9,
  parameter int                    DATA_W     = 1,
  parameter logic [POLY_ORDER-1:0] SEED       = 9'h1AA,
  parameter int                    LOCK_CNT   = 8,
  parameter int                    UNLOCK_CNT = 4,
  parameter int                    ERR_CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  i_rst_n,
  input  logic                  i_en,
  input  logic                  i_valid,
  input  logic                  i_seed_load,
  input  logic [POLY_ORDER-1:0] i_seed,
  input  logic                  i_inject_err,
  output logic [DATA_W-1:0]     o_data,
  output logic                  o_valid,
  input  logic [DATA_W-1:0]     i_rx_data,
  input  logic                  i_rx_valid,
  input  logic                  i_clr_cnt,
  output logic                  o_locked,
  output logic                  o_err_word,
  output logic [ERR_CNT_W-1:0]  o_err_cnt
);

  localparam int P   = POLY_ORDER;
  localparam int TAP = (P == 7)  ? 6  :
                       (P == 9)  ? 5  :
                       (P == 15) ? 14 :
                       (P == 23) ? 18 :
                       (P == 31) ? 28 : 0;
  localparam int TI  = (TAP > 0) ? TAP - 1 : 0;
  localparam int FW  = $clog2(P + DATA_W + 1);
  localparam int LW  = $clog2(LOCK_CNT + 1);
  localparam int UW  = $clog2(UNLOCK_CNT + 1);
  localparam int SW  = ERR_CNT_W + 7;

  if (TAP == 0 || DATA_W < 1 || DATA_W > 32) begin : g_bad_param
    $error("prbs_gen_chk: unsupported POLY_ORDER or DATA_W");
  end

  typedef enum logic [1:0] {
    S_FILL,
    S_SYNC,
    S_LOCKED
  } st_t;

  logic [P-1:0]         gen_q;
  logic [P-1:0]         gen_s;
  logic [DATA_W-1:0]    gen_word;
  logic [P-1:0]         hist_q;
  logic [P-1:0]         hist_s;
  logic [DATA_W-1:0]    mism;
  logic [5:0]           pc;
  st_t                  st_q, st_d;
  logic [FW-1:0]        fill_q, fill_d;
  logic [LW-1:0]        good_q, good_d;
  logic [UW-1:0]        bad_q, bad_d;
  logic                 ew_d;
  logic [ERR_CNT_W-1:0] cnt_d;
  logic [SW-1:0]        sum;
  logic                 add;

  // Unroll DATA_W LFSR steps; earliest bit lands in the word MSB.
  always_comb begin
    gen_s    = gen_q;
    gen_word = '0;
    for (int i = 0; i < DATA_W; i++) begin
      gen_word[DATA_W-1-i] = gen_s[P-1];
      gen_s = {gen_s[P-2:0], gen_s[P-1] ^ gen_s[TI]};
    end
  end

  // Generator state and output word; seed load beats stepping.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      gen_q   <= SEED;
      o_data  <= '0;
      o_valid <= 1'b0;
    end else if (i_seed_load) begin
      gen_q   <= (i_seed == '0) ? SEED : i_seed;
      o_valid <= 1'b0;
    end else if (i_en && i_valid) begin
      gen_q   <= gen_s;
      o_data  <= gen_word ^ DATA_W'(i_inject_err);
      o_valid <= 1'b1;
    end else begin
      o_valid <= 1'b0;
    end
  end

  // Predict each rx bit from history, earlier bits of this word included.
  always_comb begin
    hist_s = hist_q;
    mism   = '0;
    pc     = '0;
    for (int i = 0; i < DATA_W; i++) begin
      mism[DATA_W-1-i] = hist_s[P-1] ^ hist_s[TI]
                       ^ i_rx_data[DATA_W-1-i];
      pc = pc + 6'(mism[DATA_W-1-i]);
      hist_s = {hist_s[P-2:0], i_rx_data[DATA_W-1-i]};
    end
  end

  // Lock FSM next state, word flag and saturating counter.
  always_comb begin
    st_d   = st_q;
    fill_d = fill_q;
    good_d = good_q;
    bad_d  = bad_q;
    ew_d   = o_err_word;
    add    = 1'b0;
    if (i_rx_valid) begin
      ew_d = 1'b0;
      unique case (st_q)
        S_FILL: begin
          if (int'(fill_q) + DATA_W >= P) begin
            st_d   = S_SYNC;
            fill_d = '0;
            good_d = '0;
          end else begin
            fill_d = fill_q + FW'(DATA_W);
          end
        end
        S_SYNC: begin
          ew_d = |mism;
          if (|mism) begin
            good_d = '0;
          end else if (int'(good_q) + 1 >= LOCK_CNT) begin
            st_d  = S_LOCKED;
            bad_d = '0;
          end else begin
            good_d = good_q + 1'b1;
          end
        end
        S_LOCKED: begin
          ew_d = |mism;
          add  = 1'b1;
          if (!(|mism)) begin
            bad_d = '0;
          end else if (int'(bad_q) + 1 >= UNLOCK_CNT) begin
            st_d   = S_FILL;
            fill_d = '0;
          end else begin
            bad_d = bad_q + 1'b1;
          end
        end
        default: st_d = S_FILL;
      endcase
    end
    sum = SW'(o_err_cnt) + SW'(pc);
    if (i_clr_cnt) begin
      cnt_d = '0;
    end else if (add) begin
      cnt_d = (|sum[SW-1:ERR_CNT_W]) ? '1
            : sum[ERR_CNT_W-1:0];
    end else begin
      cnt_d = o_err_cnt;
    end
  end

  // Checker registers; history only moves on received words.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hist_q     <= '0;
      st_q       <= S_FILL;
      fill_q     <= '0;
      good_q     <= '0;
      bad_q      <= '0;
      o_err_word <= 1'b0;
      o_err_cnt  <= '0;
    end else begin
      if (i_rx_valid) hist_q <= hist_s;
      st_q       <= st_d;
      fill_q     <= fill_d;
      good_q     <= good_d;
      bad_q      <= bad_d;
      o_err_word <= ew_d;
      o_err_cnt  <= cnt_d;
    end
  end

  assign o_locked = (st_q == S_LOCKED);

endmodule

// File: tb/tb_prbs_gen_chk.sv
// tb_prbs_gen_chk: directed checks of the PRBS generator
// and checker across several parameter sets.
module tb_prbs_gen_chk;

  logic clk;
  logic rst_n;

  // d0: P=9 W=1 generator
  logic        en0, val0, load0, inj0;
  logic [8:0]  seed0;
  logic [0:0]  data0;
  logic        ov0;
  logic [0:0]  rxd0;
  logic        rxv0, clr0;
  logic        lk0, ew0;
  logic [15:0] cnt0;

  // d1: P=9 W=8 loopback
  logic        en1, inj1, inv, clr1, tie0;
  logic [8:0]  seedz9;
  logic [7:0]  data1, rx1;
  logic        ov1, lk1, ew1;
  logic [15:0] cnt1;

  // d2: P=31 W=1 loopback
  logic        inj2;
  logic [30:0] seedz31;
  logic [0:0]  data2;
  logic        ov2, lk2, ew2;
  logic [15:0] cnt2;

  // d3: P=9 W=8 checker, 4-bit counter
  logic [7:0]  data3;
  logic        ov3, lk3, ew3;
  logic [3:0]  cnt3;

  int n_pass;
  int n_fail;
  int n_tot;

  logic [8:0] pat;

  assign rx1 = data1 ^ {8{inv}};

  prbs_gen_chk #(.POLY_ORDER(9), .DATA_W(1),
    .SEED(9'h1AA)) d0 (
    .clk(clk), .i_rst_n(rst_n), .i_en(en0),
    .i_valid(val0), .i_seed_load(load0),
    .i_seed(seed0), .i_inject_err(inj0),
    .o_data(data0), .o_valid(ov0),
    .i_rx_data(rxd0), .i_rx_valid(rxv0),
    .i_clr_cnt(clr0), .o_locked(lk0),
    .o_err_word(ew0), .o_err_cnt(cnt0));

  prbs_gen_chk #(.POLY_ORDER(9), .DATA_W(8),
    .SEED(9'h1AA)) d1 (
    .clk(clk), .i_rst_n(rst_n), .i_en(en1),
    .i_valid(en1), .i_seed_load(tie0),
    .i_seed(seedz9), .i_inject_err(inj1),
    .o_data(data1), .o_valid(ov1),
    .i_rx_data(rx1), .i_rx_valid(ov1),
    .i_clr_cnt(clr1), .o_locked(lk1),
    .o_err_word(ew1), .o_err_cnt(cnt1));

  prbs_gen_chk #(.POLY_ORDER(31), .DATA_W(1),
    .SEED(31'h1)) d2 (
    .clk(clk), .i_rst_n(rst_n), .i_en(en1),
    .i_valid(en1), .i_seed_load(tie0),
    .i_seed(seedz31), .i_inject_err(inj2),
    .o_data(data2), .o_valid(ov2),
    .i_rx_data(data2), .i_rx_valid(ov2),
    .i_clr_cnt(tie0), .o_locked(lk2),
    .o_err_word(ew2), .o_err_cnt(cnt2));

  prbs_gen_chk #(.POLY_ORDER(9), .DATA_W(8),
    .SEED(9'h1AA), .ERR_CNT_W(4)) d3 (
    .clk(clk), .i_rst_n(rst_n), .i_en(tie0),
    .i_valid(tie0), .i_seed_load(tie0),
    .i_seed(seedz9), .i_inject_err(tie0),
    .o_data(data3), .o_valid(ov3),
    .i_rx_data(rx1), .i_rx_valid(ov1),
    .i_clr_cnt(tie0), .o_locked(lk3),
    .o_err_word(ew3), .o_err_cnt(cnt3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  initial begin
    n_pass = 0; n_fail = 0; n_tot = 0;
    pat = 9'b110101010;
    rst_n = 1'b0;
    en0 = 0; val0 = 0; load0 = 0; inj0 = 0;
    seed0 = '0; rxd0 = '0; rxv0 = 0; clr0 = 0;
    en1 = 0; inj1 = 0; inv = 0; clr1 = 0;
    tie0 = 0; seedz9 = '0; inj2 = 0;
    seedz31 = '0;
    #12 rst_n = 1'b1;
    step(2);

    // reset state
    chk("rst_ov0", ov0, 0);
    chk("rst_data0", data0, 0);
    chk("rst_ov1", ov1, 0);
    chk("rst_lk1", lk1, 0);
    chk("rst_ew1", ew1, 0);
    chk("rst_cnt1", cnt1, 0);

    // nonzero seed load 9'h0FF -> bits 0,1,1
    load0 = 1; seed0 = 9'h0FF;
    step(1);
    load0 = 0; en0 = 1; val0 = 1;
    step(1);
    chk("seedff_ov", ov0, 1);
    chk("seedff_b0", data0, 0);
    step(1);
    chk("seedff_b1", data0, 1);
    step(1);
    chk("seedff_b2", data0, 1);

    // zero seed load while stepping: load wins
    load0 = 1; seed0 = 9'h000;
    step(1);
    chk("load_wins_ov", ov0, 0);
    chk("load_hold_data", data0, 1);
    load0 = 0;
    for (int i = 0; i < 9; i++) begin
      step(1);
      chk("seq_ov", ov0, 1);
      chk($sformatf("seq_b%0d", i), data0, pat[8-i]);
    end

    // valid toggle 1,0,0,1 -> b9=1 hold hold b10=0
    step(1);
    chk("tog1_ov", ov0, 1);
    chk("tog1_b9", data0, 1);
    val0 = 0;
    step(1);
    chk("tog2_ov", ov0, 0);
    chk("tog2_hold", data0, 1);
    step(1);
    chk("tog3_ov", ov0, 0);
    chk("tog3_hold", data0, 1);
    val0 = 1;
    step(1);
    chk("tog4_ov", ov0, 1);
    chk("tog4_b10", data0, 0);

    // 11 steps done; step 511 yields b510=1, then wrap
    step(500);
    chk("b510", data0, 1);
    for (int i = 0; i < 9; i++) begin
      step(1);
      chk($sformatf("wrap_b%0d", i), data0, pat[8-i]);
    end

    // loopback lock timing
    en1 = 1;
    step(10);
    chk("d1_prelock", lk1, 0);
    step(1);
    chk("d1_lock", lk1, 1);
    chk("d3_lock", lk3, 1);
    step(28);
    chk("d2_prelock", lk2, 0);
    step(1);
    chk("d2_lock", lk2, 1);

    // ~1000 words clean
    step(990);
    chk("d1_clean_cnt", cnt1, 0);
    chk("d1_clean_lk", lk1, 1);
    chk("d1_clean_ew", ew1, 0);
    chk("d2_clean_cnt", cnt2, 0);

    // single injected bit error -> 3 mismatches
    inj1 = 1; inj2 = 1;
    step(1);
    inj1 = 0; inj2 = 0;
    step(40);
    chk("d1_inj_cnt", cnt1, 3);
    chk("d1_inj_lk", lk1, 1);
    chk("d2_inj_cnt", cnt2, 3);
    chk("d2_inj_lk", lk2, 1);
    chk("d3_inj_cnt", cnt3, 3);

    // inverted stream: words add 5,7,8,8 then unlock
    inv = 1;
    step(3);
    chk("inv_lk_still", lk1, 1);
    chk("inv_ew", ew1, 1);
    step(1);
    chk("inv_unlock", lk1, 0);
    chk("inv_cnt1", cnt1, 31);
    chk("inv_sat3", cnt3, 15);
    step(3);
    chk("inv_retain", cnt1, 31);
    chk("inv_ew_sync", ew1, 1);
    clr1 = 1;
    step(1);
    clr1 = 0;
    chk("clr_cnt", cnt1, 0);
    inv = 0;
    step(20);
    chk("relock", lk1, 1);
    chk("relock_cnt", cnt1, 0);

    // clear coincident with an errored locked word
    inv = 1; clr1 = 1;
    step(1);
    inv = 0; clr1 = 0;
    chk("clr_coinc_cnt", cnt1, 0);
    chk("clr_coinc_ew", ew1, 1);
    step(5);
    chk("after_coinc_cnt", cnt1, 5);
    chk("after_coinc_lk", lk1, 1);

    // async reset between clock edges
    #3 rst_n = 1'b0;
    #1;
    chk("arst_ov0", ov0, 0);
    chk("arst_data0", data0, 0);
    chk("arst_lk1", lk1, 0);
    chk("arst_cnt1", cnt1, 0);
    chk("arst_ov1", ov1, 0);
    #2 rst_n = 1'b1;
    step(1);
    chk("rst_seq_b0", data0, 1);
    step(1);
    chk("rst_seq_b1", data0, 1);
    step(1);
    chk("rst_seq_b2", data0, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/prbs_gen_chk.md
Name: prbs_gen_chk

Overview:
Parametrised PRBS generator and self-synchronising checker for link and BER tests. It emits DATA_W sequence bits per enabled cycle for any supported polynomial order. In parallel, it checks a received word stream against the same polynomial using a lock state machine and a saturating bit-error counter. It replaces the fixed 1-bit PRBS9 source in test datapaths and loopback benches.

Parameters:
POLY_ORDER, 9, PRBS order P. Supported: 7 (x7+x6+1), 9 (x9+x5+1), 15 (x15+x14+1), 23 (x23+x18+1), 31 (x31+x28+1). Any other value is an elaboration error.
DATA_W, 1, bits generated/checked per word, 1..32.
SEED, 9'h1AA, reset/default generator state, POLY_ORDER bits, must be nonzero.
LOCK_CNT, 8, consecutive error-free words needed to declare lock.
UNLOCK_CNT, 4, consecutive errored words needed to drop lock.
ERR_CNT_W, 16, error counter width.

Ports:
clk  in  1  clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_en  in  1  generator enable
i_valid  in  1  generator advance strobe; generator steps only when i_en && i_valid
i_seed_load  in  1  load i_seed into generator state (priority over stepping)
i_seed  in  POLY_ORDER  seed value
i_inject_err  in  1  invert o_data[0] of the word produced this cycle
o_data  out  DATA_W  generated word, earliest bit in MSB
o_valid  out  1  o_data valid
i_rx_data  in  DATA_W  received word, earliest bit in MSB
i_rx_valid  in  1  received word strobe
i_clr_cnt  in  1  synchronous clear of o_err_cnt
o_locked  out  1  checker locked
o_err_word  out  1  last checked word contained at least one mismatch
o_err_cnt  out  ERR_CNT_W  saturating count of mismatched bits while locked

Behaviour:
- Reset (async assert, sync release): generator state = SEED; o_data = 0; o_valid = 0; checker history = 0; fill count = 0; FSM = FILL; o_locked = 0; o_err_word = 0; o_err_cnt = 0.
- Sequence: b(k) = MSB of the state before step k. One step shifts the state left and inserts the feedback b(k)^b(k+P-T), where T is the lower tap (e.g. P=9: reg[8]^reg[4]). Recurrence: b(k+P) = b(k) ^ b(k+P-T).
- Generator:
  - i_seed_load takes priority and loads i_seed; a zero i_seed loads SEED instead (no lockup state).
  - Otherwise, when i_en && i_valid, the state advances DATA_W steps in one cycle.
  - o_data is registered with b(n)..b(n+DATA_W-1), MSB first; o_valid=1 on the next cycle.
  - Otherwise o_valid=0 and o_data holds its value.
  - i_inject_err is sampled with the step; it affects o_data only, never the state.
- Checker:
  - Keeps the last P received bits.
  - Each received bit r(k) is predicted as h(k-P)^h(k-T), including earlier bits of the same word, then shifted into history. No seeding is required.
  - A single line-bit error yields exactly 3 mismatches (at k, k+T, k+P).
  - Results (o_err_word, o_err_cnt, o_locked) update 1 cycle after the i_rx_valid word.
  - Checker state freezes when i_rx_valid=0.
- FSM:
  - FILL: counts received bits. Moves to SYNC once at least P bits are received; the word completing the fill is not checked.
  - SYNC: counts consecutive clean words. Any error resets the count. Reaching LOCK_CNT moves to LOCKED and sets o_locked=1.
  - LOCKED: counts consecutive errored words. A clean word resets the count. Reaching UNLOCK_CNT moves to FILL, clears o_locked and restarts fill; o_err_cnt is retained.
- Error counter:
  - Each word adds popcount(mismatch) only in LOCKED, including the word that triggers unlock.
  - Saturates at all-ones.
  - i_clr_cnt wins over a same-cycle increment (result 0).
- o_err_word updates for every checked word, in any state.
- Generator and checker are independent; both may be active in the same cycle.

Test Plan:
- P=9, W=1, reset, i_en=i_valid=1 -> o_valid rises 1 cycle later; first 9 o_data bits 1,1,0,1,0,1,0,1,0; generator state returns to 9'h1AA after exactly 511 steps.
- Toggle i_valid 1,0,0,1 -> o_valid follows with 1-cycle delay, o_data holds across gaps; i_seed_load with i_seed=0 -> state=9'h1AA; i_seed_load with i_en=i_valid=1 -> the load wins.
- Loopback W=8, P=9: o_data->i_rx_data, o_valid->i_rx_valid -> o_locked=1 after 2 fill words + 8 clean words; o_err_cnt=0 after 1000 words.
- Locked loopback, pulse i_inject_err once -> o_err_cnt=3, o_locked stays 1; repeat with W=1, P=31 -> o_err_cnt=3.
- Locked, then feed inverted o_data -> every word errored, o_locked=0 within UNLOCK_CNT+2 words, o_err_cnt retained; then i_clr_cnt -> 0; i_clr_cnt coincident with an errored locked word -> 0; ERR_CNT_W=4 under continuous errors -> saturates at 15.
- Assert i_rst_n low between clock edges mid-stream -> all outputs reach reset values immediately without a clock edge; after release, the sequence restarts from SEED.
